ycbcr_conv_pipe: RTL and testbench

Pipelined, parametrised RGB→YCbCr colour converter with valid/ready handshake, round-to-nearest and saturation. It sits between the pixel source and the 8x8 block buffer feeding the DCT. It emits level-shifted, signed Y/Cb/Cr (Y−128, Cb and Cr centred on 0), ready for the DCT. It supersedes the combinational Q8.16 converter: outputs are registered, rounded and clamped to OUT_W.

---
 rtl/ycbcr_pkg.sv | 33 +++
 rtl/ycbcr_round_sat.sv | 47 ++++
 rtl/ycbcr_conv_pipe.sv | 147 ++++++++++++++
 tb/tb_ycbcr_conv_pipe.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ycbcr_pkg.sv
// Shared constants for the RGB->YCbCr pipeline: 16-bit reference coefficients,
// their rescaling to a narrower fractional width, and the accumulator width rule.
// Pure declarations; no logic, no latency, no flow control.
package ycbcr_pkg;

  // Coefficients are defined once at this fractional width and truncated down.
  localparam int COEF_REF_W = 16;

  // Headroom over the product width so a sum of three signed terms cannot overflow.
  localparam int SUM_GUARD_W = 3;

  // Magnitudes in row order Y(r,g,b), Cb(r,g,b), Cr(r,g,b).
  localparam logic [COEF_REF_W-1:0] COEF_MAG [9] = '{
    16'h4C8B, 16'h9645, 16'h1D2F,
    16'h2B32, 16'h54CD, 16'h8000,
    16'h8000, 16'h6B2F, 16'h14D0
  };

  // Bit i set means coefficient i is subtracted (Cb r/g, Cr g/b).
  localparam logic [8:0] COEF_NEG = 9'b110011000;

  // Truncate a reference coefficient to coef_w fractional bits.
  function automatic logic [COEF_REF_W-1:0] scale_coef(input logic [COEF_REF_W-1:0] k,
                                                       input int coef_w);
    return k >> (COEF_REF_W - coef_w);
  endfunction

  // Width of the signed per-component accumulator.
  function automatic int sum_width(input int in_w, input int coef_w);
    return in_w + coef_w + SUM_GUARD_W;
  endfunction

endpackage

// File: rtl/ycbcr_round_sat.sv
// Round half toward +inf, drop the fraction, optional luma level shift, clamp to OUT_W.
// Purely combinational; zero latency.
// No flow control; the enclosing stage register decides when the result is captured.
module ycbcr_round_sat #(
  parameter int SUM_W  = 27,
  parameter int COEF_W = 16,
  parameter int IN_W   = 8,
  parameter int OUT_W  = 8,
  parameter bit LUMA   = 1'b0
) (
  input  logic signed [SUM_W-1:0] sum,
  output logic        [OUT_W-1:0] res
`ifdef YCBCR_SAT_CNT_EN
  ,
  output logic                    sat
`endif
);

  localparam logic signed [SUM_W-1:0] RND  = SUM_W'(2 ** (COEF_W - 1));
  localparam logic signed [SUM_W-1:0] OFS  = LUMA ? SUM_W'(2 ** (IN_W - 1)) : '0;
  localparam logic signed [SUM_W-1:0] MAXV = SUM_W'(2 ** (OUT_W - 1) - 1);
  // ~MAXV is -MAXV-1, i.e. the most negative OUT_W value.
  localparam logic signed [SUM_W-1:0] MINV = ~MAXV;

  logic signed [SUM_W-1:0] biased;
  logic signed [SUM_W-1:0] shifted;
  logic signed [SUM_W-1:0] lvl;
  logic                    hi;
  logic                    lo;

  // Round, shift, level-shift, then clamp into the signed output range.
  always_comb begin
    biased  = sum + RND;
    shifted = biased >>> COEF_W;
    lvl     = shifted - OFS;
    hi      = lvl > MAXV;
    lo      = lvl < MINV;
    res     = lvl[OUT_W-1:0];
    if (hi)      res = MAXV[OUT_W-1:0];
    else if (lo) res = MINV[OUT_W-1:0];
  end

`ifdef YCBCR_SAT_CNT_EN
  assign sat = hi | lo;
`endif

endmodule

// File: rtl/ycbcr_conv_pipe.sv
// RGB->YCbCr converter, level-shifted signed outputs; YCBCR_SAT_CNT_EN adds sat_cnt.
// Latency 3 cycles (products, sums, round/clamp), 1 pixel/clk throughput.
// One global advance = !out_valid | out_ready; a stalled output freezes every stage.
module ycbcr_conv_pipe
  import ycbcr_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_r,
  input  logic [IN_W-1:0]  in_g,
  input  logic [IN_W-1:0]  in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_y,
  output logic [OUT_W-1:0] out_cb,
  output logic [OUT_W-1:0] out_cr,
  output logic             out_last
`ifdef YCBCR_SAT_CNT_EN
  ,
  output logic [15:0]      sat_cnt
`endif
);

  localparam int PROD_W = IN_W + COEF_W;
  localparam int SUM_W  = sum_width(IN_W, COEF_W);

  logic                    advance;
  logic [IN_W-1:0]         samp    [3];
  logic                    vld1, vld2, last1, last2;
  logic [PROD_W-1:0]       prod1   [9];
  logic signed [SUM_W-1:0] sum_nxt [3];
  logic signed [SUM_W-1:0] sum2    [3];
  logic [OUT_W-1:0]        res     [3];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Gather the colour samples so products can be indexed uniformly.
  always_comb begin
    samp[0] = in_r;
    samp[1] = in_g;
    samp[2] = in_b;
  end

  // S1: nine unsigned sample x |coefficient| products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1  <= 1'b0;
      last1 <= 1'b0;
      for (int i = 0; i < 9; i++) prod1[i] <= '0;
    end else if (advance) begin
      vld1  <= in_valid;
      last1 <= in_last;
      for (int i = 0; i < 9; i++)
        prod1[i] <= PROD_W'(samp[i % 3]) * PROD_W'(scale_coef(COEF_MAG[i], COEF_W));
    end
  end

  // Signed per-component sums, applying each coefficient's sign.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      sum_nxt[c] = '0;
      for (int j = 0; j < 3; j++) begin
        if (COEF_NEG[3*c+j]) sum_nxt[c] = sum_nxt[c] - SUM_W'(prod1[3*c+j]);
        else                 sum_nxt[c] = sum_nxt[c] + SUM_W'(prod1[3*c+j]);
      end
    end
  end

  // S2: register the three sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld2  <= 1'b0;
      last2 <= 1'b0;
      for (int c = 0; c < 3; c++) sum2[c] <= '0;
    end else if (advance) begin
      vld2  <= vld1;
      last2 <= last1;
      for (int c = 0; c < 3; c++) sum2[c] <= sum_nxt[c];
    end
  end

`ifdef YCBCR_SAT_CNT_EN
  logic [2:0] sat_c;
  logic       sat3;
`endif

  ycbcr_round_sat #(.SUM_W(SUM_W), .COEF_W(COEF_W), .IN_W(IN_W), .OUT_W(OUT_W), .LUMA(1'b1))
    u_rs_y  (.sum(sum2[0]), .res(res[0])
`ifdef YCBCR_SAT_CNT_EN
             , .sat(sat_c[0])
`endif
            );
  ycbcr_round_sat #(.SUM_W(SUM_W), .COEF_W(COEF_W), .IN_W(IN_W), .OUT_W(OUT_W), .LUMA(1'b0))
    u_rs_cb (.sum(sum2[1]), .res(res[1])
`ifdef YCBCR_SAT_CNT_EN
             , .sat(sat_c[1])
`endif
            );
  ycbcr_round_sat #(.SUM_W(SUM_W), .COEF_W(COEF_W), .IN_W(IN_W), .OUT_W(OUT_W), .LUMA(1'b0))
    u_rs_cr (.sum(sum2[2]), .res(res[2])
`ifdef YCBCR_SAT_CNT_EN
             , .sat(sat_c[2])
`endif
            );

  // S3: registered outputs, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_y     <= '0;
      out_cb    <= '0;
      out_cr    <= '0;
    end else if (advance) begin
      out_valid <= vld2;
      out_last  <= last2;
      out_y     <= res[0];
      out_cb    <= res[1];
      out_cr    <= res[2];
    end
  end

`ifdef YCBCR_SAT_CNT_EN
  // Clamp flag travels with the output pixel it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sat3 <= 1'b0;
    else if (advance) sat3 <= |sat_c;
  end

  // Count delivered pixels that needed clamping; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_cnt <= '0;
    else if (out_valid && out_ready && sat3 && (sat_cnt != 16'hFFFF))
      sat_cnt <= sat_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ycbcr_conv_pipe.sv
// Self-checking bench for ycbcr_conv_pipe: directed colours, random pixels,
// a back-pressured 64-pixel stream and an asynchronous mid-stream reset.
// Expected values come from an integer floor-division model of the colour matrix.
module tb_ycbcr_conv_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_last;
  logic [7:0] in_r, in_g, in_b;
  logic       out_valid, out_ready, out_last;
  logic [7:0] out_y, out_cb, out_cr;
`ifdef YCBCR_SAT_CNT_EN
  logic [15:0] sat_cnt;
  int          sat_tally = 0;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    int y;
    int cb;
    int cr;
    bit last;
    bit sat;
  } pix_t;

  always #5 clk = ~clk;

  ycbcr_conv_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_cb(out_cb), .out_cr(out_cr), .out_last(out_last)
`ifdef YCBCR_SAT_CNT_EN
    , .sat_cnt(sat_cnt)
`endif
  );

  function automatic int fdiv(input int a, input int d);
    int q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int clamp8(input int v);
    return (v > 127) ? 127 : ((v < -128) ? -128 : v);
  endfunction

  function automatic pix_t model(input int r, input int g, input int b, input bit last);
    pix_t p;
    int y, cb, cr;
    y  = fdiv(19595 * r + 38469 * g + 7471 * b + 32768, 65536) - 128;
    cb = fdiv(-11058 * r - 21709 * g + 32768 * b + 32768, 65536);
    cr = fdiv(32768 * r - 27439 * g - 5328 * b + 32768, 65536);
    p.y    = clamp8(y);
    p.cb   = clamp8(cb);
    p.cr   = clamp8(cr);
    p.sat  = (p.y != y) || (p.cb != cb) || (p.cr != cr);
    p.last = last;
    return p;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: got valid=%b last=%b want 0 0", out_valid, out_last);
    end
    total++;
    if (out_y !== 8'h00 || out_cb !== 8'h00 || out_cr !== 8'h00) begin
      bad++;
      $display("FAIL reset_data: got %h %h %h want 00 00 00", out_y, out_cb, out_cr);
    end
`ifdef YCBCR_SAT_CNT_EN
    total++;
    if (sat_cnt !== 16'h0) begin
      bad++;
      $display("FAIL reset_sat_cnt: got %0d want 0", sat_cnt);
    end
`endif
    #2 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  // One isolated pixel: latency, values, single-cycle out_valid.
  task automatic send_one(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input pix_t exp, input string name);
    int lat = 0;
    @(negedge clk);
    out_ready = 1'b1;
    in_r = r; in_g = g; in_b = b; in_last = 1'b0; in_valid = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    total++;
    if (lat != 3) begin
      bad++;
      $display("FAIL %s_latency: got %0d want 3", name, lat);
    end
    total++;
    if (out_y !== 8'(exp.y) || out_cb !== 8'(exp.cb) || out_cr !== 8'(exp.cr)) begin
      bad++;
      $display("FAIL %s_value: got y=%0d cb=%0d cr=%0d want y=%0d cb=%0d cr=%0d", name,
               $signed(out_y), $signed(out_cb), $signed(out_cr), exp.y, exp.cb, exp.cr);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_pulse: got out_valid=%b want 0", name, out_valid);
    end
`ifdef YCBCR_SAT_CNT_EN
    if (exp.sat) sat_tally++;
    total++;
    if (sat_cnt !== 16'(sat_tally)) begin
      bad++;
      $display("FAIL %s_sat_cnt: got %0d want %0d", name, sat_cnt, sat_tally);
    end
`endif
  endtask

  task automatic test_directed();
    send_one(8'd255, 8'd255, 8'd255, pix_t'{127, 0, 0, 1'b0, 1'b0}, "white");
    send_one(8'd0,   8'd0,   8'd0,   pix_t'{-128, 0, 0, 1'b0, 1'b0}, "black");
    send_one(8'd255, 8'd0,   8'd0,   pix_t'{-52, -43, 127, 1'b0, 1'b1}, "red");
    send_one(8'd0,   8'd0,   8'd255, pix_t'{-99, 127, -21, 1'b0, 1'b1}, "blue");
  endtask

  task automatic test_random_single();
    logic [7:0] r, g, b;
    for (int i = 0; i < 4; i++) begin
      r = 8'($urandom_range(0, 255));
      g = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      send_one(r, g, b, model(r, g, b, 1'b0), "rand");
    end
  endtask

  task automatic test_back_to_back();
    pix_t       q[$];
    pix_t       e;
    int         sent = 0, rcvd = 0, cyc = 0;
    bit         stall = 0, taken = 0;
    logic [7:0] hy = 0, hcb = 0, hcr = 0;
    logic       hl = 0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    while (rcvd < 64 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (stall) begin
        total++;
        if (out_valid !== 1'b1 || out_y !== hy || out_cb !== hcb || out_cr !== hcr || out_last !== hl) begin
          bad++;
          $display("FAIL b2b_hold: got v=%b %h %h %h l=%b want v=1 %h %h %h l=%b",
                   out_valid, out_y, out_cb, out_cr, out_last, hy, hcb, hcr, hl);
        end
      end
      if (taken) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        taken    = 0;
      end
      if (sent < 64 && !in_valid) begin
        in_r = 8'($urandom_range(0, 255));
        in_g = 8'($urandom_range(0, 255));
        in_b = 8'($urandom_range(0, 255));
        in_last  = (sent == 63);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      stall = out_valid && !out_ready;
      if (stall) begin
        hy = out_y; hcb = out_cb; hcr = out_cr; hl = out_last;
        total++;
        if (in_ready !== 1'b0) begin
          bad++;
          $display("FAIL b2b_in_ready_stall: got %b want 0", in_ready);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra_output: got output %0d want none", rcvd);
        end else begin
          e = q.pop_front();
`ifdef YCBCR_SAT_CNT_EN
          if (e.sat) sat_tally++;
`endif
          if (out_y !== 8'(e.y) || out_cb !== 8'(e.cb) || out_cr !== 8'(e.cr) || out_last !== e.last) begin
            bad++;
            $display("FAIL b2b_pixel%0d: got y=%0d cb=%0d cr=%0d last=%b want y=%0d cb=%0d cr=%0d last=%b",
                     rcvd, $signed(out_y), $signed(out_cb), $signed(out_cr), out_last,
                     e.y, e.cb, e.cr, e.last);
          end
        end
        rcvd++;
      end
      if (in_valid && in_ready === 1'b1) begin
        q.push_back(model(in_r, in_g, in_b, in_last));
        sent++;
        taken = 1;
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    total++;
    if (rcvd != 64 || sent != 64 || q.size() != 0) begin
      bad++;
      $display("FAIL b2b_count: got sent=%0d rcvd=%0d left=%0d want 64 64 0", sent, rcvd, q.size());
    end
`ifdef YCBCR_SAT_CNT_EN
    total++;
    if (sat_cnt !== 16'(sat_tally)) begin
      bad++;
      $display("FAIL b2b_sat_cnt: got %0d want %0d", sat_cnt, sat_tally);
    end
`endif
  endtask

  task automatic test_reset_midstream();
    logic [7:0] r, g, b;
    int         stale = 0;
    @(negedge clk);
    out_ready = 1'b0;
    in_r = 8'd10; in_g = 8'd200; in_b = 8'd30; in_last = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_r = 8'd90; in_g = 8'd5; in_b = 8'd250; in_last = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre_valid: got %b want 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_y !== 8'h00) begin
      bad++;
      $display("FAIL rst_async: got v=%b l=%b y=%h want 0 0 00", out_valid, out_last, out_y);
    end
`ifdef YCBCR_SAT_CNT_EN
    sat_tally = 0;
`endif
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    total++;
    if (stale != 0) begin
      bad++;
      $display("FAIL rst_stale: got %0d cycles with out_valid want 0", stale);
    end
    r = 8'($urandom_range(0, 255));
    g = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    send_one(r, g, b, model(r, g, b, 1'b0), "post_rst");
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_r = '0; in_g = '0; in_b = '0; out_ready = 1'b1;
    test_reset();
    test_directed();
    test_random_single();
    test_back_to_back();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
